// File: rtl/pipe_mips_hz.sv
// pipe_mips_hz: 5-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with load-use interlock, branch flush,
// imem load port, run/freeze and retire counter. Define PIPE_MIPS_HZ_FORWARDING_EN to enable forwarding.
module pipe_mips_hz #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'd0,
  localparam int         IMEM_AW    = $clog2(IMEM_DEPTH),
  localparam int         DMEM_AW    = $clog2(DMEM_DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  input  logic [4:0]         dbg_raddr,
  output logic [31:0]        dbg_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        ifid_ir,
  output logic [31:0]        idex_ir,
  output logic [31:0]        exmem_ir,
  output logic [31:0]        memwb_ir,
  output logic [31:0]        wd,
  output logic               wb_valid,
  output logic               stall,
  output logic               flush,
  output logic [31:0]        retired
);
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;

  function automatic logic r_ok(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_R && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
  endfunction

  function automatic logic use_rs(input logic [5:0] op, input logic [5:0] fn);
    return r_ok(op, fn) || (op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI});
  endfunction

  function automatic logic use_rt(input logic [5:0] op, input logic [5:0] fn);
    return r_ok(op, fn) || (op inside {OP_SW, OP_BEQ, OP_BNE});
  endfunction

  // Destination register, or 0 when the instruction writes nothing ($0 writes are dropped the same way).
  function automatic logic [4:0] wdest(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rt, input logic [4:0] rd);
    if (r_ok(op, fn))                return rd;
    else if (op inside {OP_LW, OP_ADDI}) return rt;
    else                             return 5'd0;
  endfunction

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] regs [32];
  logic [31:0] ifid_pc4, idex_pc4, idex_a, idex_b, exmem_alu, exmem_b;

  // IF
  logic [31:0] if_ir, pc4;
  assign if_ir = imem[pc[IMEM_AW+1:2]];
  assign pc4   = pc + 32'd4;

  // ID with write-through from WB
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst, wb_dst;
  logic [31:0] id_a, id_b;
  logic        id_use_rs, id_use_rt, dep_ex;
  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign id_use_rs = use_rs(ifid_ir[31:26], ifid_ir[5:0]);
  assign id_use_rt = use_rt(ifid_ir[31:26], ifid_ir[5:0]);
  assign ex_dst    = wdest(idex_ir[31:26], idex_ir[5:0], idex_ir[20:16], idex_ir[15:11]);
  assign mem_dst   = wdest(exmem_ir[31:26], exmem_ir[5:0], exmem_ir[20:16], exmem_ir[15:11]);
  assign wb_dst    = wdest(memwb_ir[31:26], memwb_ir[5:0], memwb_ir[20:16], memwb_ir[15:11]);
  assign id_a      = (wb_dst != 5'd0 && wb_dst == id_rs) ? wd : regs[id_rs];
  assign id_b      = (wb_dst != 5'd0 && wb_dst == id_rt) ? wd : regs[id_rt];
  assign dbg_rdata = regs[dbg_raddr];

  assign dep_ex = ex_dst != 5'd0 &&
                  ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));

  logic [31:0] ex_a, ex_b;
`ifdef PIPE_MIPS_HZ_FORWARDING_EN
  logic [4:0] ex_rs, ex_rt;
  logic       fwd_mem_ok;
  assign stall      = dep_ex && idex_ir[31:26] == OP_LW;
  assign ex_rs      = idex_ir[25:21];
  assign ex_rt      = idex_ir[20:16];
  // A load in MEM has no ALU-ready data; the load-use stall guarantees nobody needs it there.
  assign fwd_mem_ok = mem_dst != 5'd0 && exmem_ir[31:26] != OP_LW;

  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    ex_a = idex_a;
    ex_b = idex_b;
    if (fwd_mem_ok && mem_dst == ex_rs)             ex_a = exmem_alu;
    else if (wb_dst != 5'd0 && wb_dst == ex_rs)     ex_a = wd;
    if (fwd_mem_ok && mem_dst == ex_rt)             ex_b = exmem_alu;
    else if (wb_dst != 5'd0 && wb_dst == ex_rt)     ex_b = wd;
  end
`else
  logic dep_mem;
  assign dep_mem = mem_dst != 5'd0 &&
                   ((id_use_rs && id_rs == mem_dst) || (id_use_rt && id_rt == mem_dst));
  assign stall   = dep_ex || dep_mem;
  assign ex_a    = idex_a;
  assign ex_b    = idex_b;
`endif

  // EX: ALU, branch resolution
  logic [31:0] ex_imm, ex_opb, ex_alu, ex_target;
  assign ex_imm    = {{16{idex_ir[15]}}, idex_ir[15:0]};
  assign ex_opb    = (idex_ir[31:26] inside {OP_LW, OP_SW, OP_ADDI}) ? ex_imm : ex_b;
  assign ex_target = idex_pc4 + {ex_imm[29:0], 2'b00};
  assign flush     = (idex_ir[31:26] == OP_BEQ && ex_a == ex_b) ||
                     (idex_ir[31:26] == OP_BNE && ex_a != ex_b);

  always_comb begin
    ex_alu = ex_a + ex_opb;
    if (idex_ir[31:26] == OP_R) begin
      case (idex_ir[5:0])
        6'h22:   ex_alu = ex_a - ex_b;
        6'h24:   ex_alu = ex_a & ex_b;
        6'h25:   ex_alu = ex_a | ex_b;
        6'h27:   ex_alu = ~(ex_a | ex_b);
        6'h2A:   ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
        default: ex_alu = ex_a + ex_b;
      endcase
    end
  end

  // MEM
  logic [31:0] mem_rdata, mem_wd;
  assign mem_rdata = dmem[exmem_alu[DMEM_AW+1:2]];
  assign mem_wd    = (exmem_ir[31:26] == OP_LW) ? mem_rdata : exmem_alu;
  assign wb_valid  = |memwb_ir;

  // NOTE: instruction and data memories carry no reset; only architectural registers are cleared.
  always_ff @(posedge clock) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset_n && run && exmem_ir[31:26] == OP_SW) dmem[exmem_alu[DMEM_AW+1:2]] <= exmem_b;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (run && wb_dst != 5'd0) begin
      regs[wb_dst] <= wd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      ifid_ir   <= '0;
      ifid_pc4  <= '0;
      idex_ir   <= '0;
      idex_pc4  <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      exmem_ir  <= '0;
      exmem_alu <= '0;
      exmem_b   <= '0;
      memwb_ir  <= '0;
      wd        <= '0;
      retired   <= '0;
    end else if (run) begin
      // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value.
      retired   <= retired + {31'd0, wb_valid};
      memwb_ir  <= exmem_ir;
      wd        <= mem_wd;
      exmem_ir  <= idex_ir;
      exmem_alu <= ex_alu;
      exmem_b   <= ex_b;
      if (flush || stall) begin
        idex_ir  <= '0;
        idex_pc4 <= '0;
        idex_a   <= '0;
        idex_b   <= '0;
      end else begin
        idex_ir  <= ifid_ir;
        idex_pc4 <= ifid_pc4;
        idex_a   <= id_a;
        idex_b   <= id_b;
      end
      // Flush outranks stall: the held ID instruction is squashed.
      if (flush) begin
        pc       <= ex_target;
        ifid_ir  <= '0;
        ifid_pc4 <= '0;
      end else if (!stall) begin
        pc       <= pc4;
        ifid_ir  <= if_ir;
        ifid_pc4 <= pc4;
      end
    end
  end
endmodule

// File: tb/tb_pipe_mips_hz.sv
// Directed bench for pipe_mips_hz: writeback scoreboard plus final register, counter and hazard checks.
module tb_pipe_mips_hz;
  logic        clock = 1'b0, reset_n = 1'b0, run = 1'b0, imem_we = 1'b0;
  logic [9:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata, pc, ifid_ir, idex_ir, exmem_ir, memwb_ir, wd, retired;
  logic        wb_valid, stall, flush;

`ifdef PIPE_MIPS_HZ_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_mips_hz dut (
    .clock(clock), .reset_n(reset_n), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
    .ifid_ir(ifid_ir), .idex_ir(idex_ir), .exmem_ir(exmem_ir), .memwb_ir(memwb_ir), .wd(wd),
    .wb_valid(wb_valid), .stall(stall), .flush(flush), .retired(retired)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int n_stall = 0, n_flush = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_wb[$];
  logic [31:0] prog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input int op, input int rs, input int rt, input int imm);
    logic [31:0] o, s, t, m;
    o = op; s = rs; t = rt; m = imm;
    return {o[5:0], s[4:0], t[4:0], m[15:0]};
  endfunction

  function automatic logic [31:0] er(input int fn, input int rs, input int rt, input int rd);
    logic [31:0] f, s, t, d;
    f = fn; s = rs; t = rt; d = rd;
    return {6'h00, s[4:0], t[4:0], d[4:0], 5'd0, f[5:0]};
  endfunction

  function automatic bit tb_writes(input logic [31:0] ir);
    case (ir[31:26])
      6'h00:        return ir[15:11] != 5'd0 && (ir[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
      6'h23, 6'h08: return ir[20:16] != 5'd0;
      default:      return 1'b0;
    endcase
  endfunction

  // Scoreboard consumer: every register-writing instruction leaving WB pops one expected value.
  always @(negedge clock) begin
    if (reset_n && run) begin
      if (stall) n_stall++;
      if (flush) n_flush++;
      if (wb_valid && tb_writes(memwb_ir)) begin
        if (sb.size() == 0) check("sb_extra_wb_ir", memwb_ir, 32'd0);
        else check("wb_data", wd, sb.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic imem_write(input int a, input logic [31:0] d);
    imem_we = 1'b1; imem_addr = a[9:0]; imem_wdata = d;
    step(1);
    imem_we = 1'b0;
  endtask

  task automatic release_rst();
    reset_n = 1'b1; n_stall = 0; n_flush = 0;
    sb.delete();
    foreach (exp_wb[i]) sb.push_back(exp_wb[i]);
  endtask

  task automatic load_and_start();
    reset_n = 1'b0; run = 1'b1;
    for (int i = 0; i < 128; i++) imem_write(i, (i < prog.size()) ? prog[i] : 32'd0);
    release_rst();
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_raddr = r[4:0]; #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic chk_end(input string tag, input int ret, input int st, input int fl);
    check({tag, "_retired"}, retired, ret);
    check({tag, "_stalls"}, n_stall, st);
    check({tag, "_flushes"}, n_flush, fl);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic build_abs(input int a, input int b);
    prog = {ei(8,0,1,a), ei('h2B,0,1,0), ei(8,0,1,b), ei('h2B,0,1,4), ei('h23,0,9,0), ei('h23,0,10,4),
            er('h2A,9,10,12), ei(4,12,0,4), ei('h2B,0,10,0), ei('h2B,0,9,4), er('h22,10,9,11),
            ei(4,0,0,1), er('h22,9,10,11), ei('h23,0,13,0), ei('h23,0,14,4)};
    exp_wb = {a, b, a, b, (a < b) ? 1 : 0, 2, (a < b) ? b : a, (a < b) ? a : b};
  endtask

  logic [31:0] f_pc, f_ifid, f_idex, f_exmem, f_memwb, f_ret, f_wd, f_r1;

  initial begin
    // Reset state
    step(2);
    check("rst_pc", pc, 32'd0);
    check("rst_ifid", ifid_ir, 32'd0);
    check("rst_idex", idex_ir, 32'd0);
    check("rst_exmem", exmem_ir, 32'd0);
    check("rst_memwb", memwb_ir, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_flags", {29'd0, wb_valid, stall, flush}, 32'd0);

    // Back-to-back ALU, no nops
    prog   = {ei(8,0,1,5), ei(8,1,2,7), er('h22,2,1,3)};
    exp_wb = {32'd5, 32'd12, 32'd7};
    load_and_start(); step(40);
    chk_reg("alu_r3", 3, 32'd7);
    chk_reg("alu_r2", 2, 32'd12);
    chk_end("alu", 3, FWD ? 0 : 4, 0);

    // Load-use
    prog   = {ei(8,0,1,5), ei(8,0,2,7), ei('h2B,0,1,0), ei('h2B,0,2,4), ei('h23,0,9,0), ei('h23,0,10,4),
              er('h2A,9,10,11)};
    exp_wb = {32'd5, 32'd7, 32'd5, 32'd7, 32'd1};
    load_and_start(); step(40);
    chk_reg("lu_r11", 11, 32'd1);
    chk_end("lu", 7, FWD ? 1 : 3, 0);

    // Branches: beq taken, bne taken, bne not taken
    prog   = {ei(4,0,0,2), ei(8,0,5,1), ei(8,0,5,2), ei(8,0,6,3), ei(5,6,0,2), ei(8,0,7,1), ei(8,0,7,2),
              ei(5,0,0,2), ei(8,0,8,4)};
    exp_wb = {32'd3, 32'd4};
    load_and_start(); step(40);
    chk_reg("br_r5", 5, 32'd0);
    chk_reg("br_r6", 6, 32'd3);
    chk_reg("br_r7", 7, 32'd0);
    chk_reg("br_r8", 8, 32'd4);
    chk_end("br", 5, FWD ? 0 : 2, 2);

    // Absolute value 5/7 with a mid-run reset
    build_abs(5, 7);
    load_and_start(); step(9);
    reset_n = 1'b0; #1;
    check("mrst_pc", pc, 32'd0);
    check("mrst_irs", ifid_ir | idex_ir | exmem_ir | memwb_ir, 32'd0);
    check("mrst_retired", retired, 32'd0);
    check("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk_reg("mrst_r1", 1, 32'd0);
    step(1);
    release_rst();
    @(negedge clock);
    check("rel_pc_hold", pc, 32'd0);
    step(1);
    check("rel_pc", pc, 32'd4);
    check("rel_ifid", ifid_ir, prog[0]);
    step(60);
    chk_reg("abs57_r11", 11, 32'd2);
    chk_reg("abs57_r12", 12, 32'd1);
    chk_reg("abs57_r13", 13, 32'd7);
    chk_reg("abs57_r14", 14, 32'd5);
    chk_end("abs57", 14, FWD ? 1 : 8, 1);

    // Absolute value 7/5 with a 10-cycle freeze and imem writes to an unreached word
    build_abs(7, 5);
    load_and_start(); step(8);
    run = 1'b0; dbg_raddr = 5'd1; #1;
    f_pc = pc; f_ifid = ifid_ir; f_idex = idex_ir; f_exmem = exmem_ir; f_memwb = memwb_ir;
    f_ret = retired; f_wd = wd; f_r1 = dbg_rdata;
    for (int k = 0; k < 10; k++) imem_write(100, ei(8,0,20,k));
    #1;
    check("frz_pc", pc, f_pc);
    check("frz_ifid", ifid_ir, f_ifid);
    check("frz_idex", idex_ir, f_idex);
    check("frz_exmem", exmem_ir, f_exmem);
    check("frz_memwb", memwb_ir, f_memwb);
    check("frz_retired", retired, f_ret);
    check("frz_wd", wd, f_wd);
    chk_reg("frz_r1", 1, f_r1);
    run = 1'b1; step(60);
    chk_reg("abs75_r11", 11, 32'd2);
    chk_reg("abs75_r12", 12, 32'd0);
    chk_reg("abs75_r13", 13, 32'd7);
    chk_reg("abs75_r14", 14, 32'd5);
    chk_reg("abs75_r20", 20, 32'd0);
    chk_end("abs75", 11, FWD ? 1 : 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_mips_hz.md
Name: pipe_mips_hz

Overview:
- Parametrised successor to the team's 5-stage behavioural MIPS pipeline: IF, ID, EX, MEM, WB.
- Adds an integrated hazard unit (load-use interlock, branch flush), asynchronous reset, an instruction-memory load port, a run/freeze control and a retired-instruction counter.
- Programs no longer need hand-inserted nops.
- Sits as the top-level CPU under the test bench; debug outputs mirror the pipeline-monitor columns.

Parameters:
- IMEM_DEPTH, 1024, instruction memory words (power of 2).
- DMEM_DEPTH, 1024, data memory words (power of 2).
- RESET_PC, 0, byte address loaded into PC on reset.
- Derived widths:
  - IMEM_AW = clog2(IMEM_DEPTH)
  - DMEM_AW = clog2(DMEM_DEPTH)

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = pipeline advances; 0 = all pipeline state frozen.
- imem_we  in  1  instruction memory write strobe (honoured any time).
- imem_addr  in  IMEM_AW  word address for imem_we.
- imem_wdata  in  32  instruction word to write.
- dbg_raddr  in  5  register index for debug read.
- dbg_rdata  out  32  combinational Regs[dbg_raddr].
- pc  out  32  current fetch PC.
- ifid_ir, idex_ir, exmem_ir, memwb_ir  out  32 each  stage instruction words (bubble = 0).
- wd  out  32  writeback data.
- wb_valid  out  1  non-bubble instruction in WB this cycle.
- stall  out  1  ID interlock active this cycle.
- flush  out  1  taken branch squashing IF/ID and ID/EX this cycle.
- retired  out  32  count of non-bubble instructions completed in WB.

Behaviour:
- Reset (async assert, sync-release-safe):
  - pc=RESET_PC; all stage IRs and control bits = 0 (nop bubble).
  - Regs[0..31]=0; retired=0; wb_valid=stall=flush=0.
  - IMEM and DMEM not cleared.
- ISA subset; anything else decodes as nop with no side effects:
  - R-type op 0, funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A (signed compare).
  - I-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08.
  - Imm sign-extended; word addresses = byte address >> 2, modulo depth; no overflow traps.
- Register file:
  - Writes on posedge from WB; writes to $0 ignored.
  - Write-through: an ID read of the register being written in the same cycle returns wd.
- Branch:
  - Resolved in EX; target = PC+4 + (imm<<2).
  - Taken: pc<=target next edge; IF/ID and ID/EX become bubbles; flush=1 that cycle. Penalty 2 cycles.
  - Not taken: no penalty.
- Hazards (with FORWARDING_EN):
  - EX operands are muxed from EX/MEM ALU result (priority), then MEM/WB wd, then ID/EX regs; rd=0 never forwarded.
  - Load-use: lw in EX whose rt matches ID rs, or rt for R-type/sw/branch, holds PC and IF/ID, inserts one bubble into EX; stall=1 for 1 cycle.
  - sw data is forwarded identically.
- Simultaneous stall and flush: flush wins; stalled instruction discarded.
- run=0: no register, memory, PC or counter update; imem writes still occur.
- Latency: an instruction fetched at cycle n writes back at n+4 absent stalls/flushes.
- retired: increments when wb_valid; wraps at 2^32.
- Reset mid-operation: in-flight instructions discarded immediately; pending DMEM write in the same cycle suppressed.

Optional Feature:
- Macro: PIPE_MIPS_HZ_FORWARDING_EN.
- Defined: forwarding as above; load-use is the only stall (1 cycle).
- Undefined: no forwarding paths. ID stalls while any instruction in EX or MEM writes a nonzero register that ID reads (WB covered by write-through). A dependent instruction immediately after its producer stalls 2 cycles; load-use also costs 2.

Test Plan:
- Reset: hold reset_n=0 mid-run with non-zero state -> pc=0, all IRs 0, retired=0 immediately; release -> fetch from 0 next posedge.
- Back-to-back ALU, nop-free: addi $1,$0,5; addi $2,$1,7; sub $3,$2,$1 -> $3=7. Stall never asserted with the macro; without it, stall cycles total 4.
- Load-use: DMEM[0]=5, DMEM[1]=7; lw $9,0($0); lw $10,4($0); slt $11,$9,$10 -> $11=1; exactly one stall cycle with the macro.
- Branch: beq $0,$0,+2 followed by two addi $5 writes -> flush=1 once; $5 unchanged; retired excludes squashed instructions. bne taken/not-taken both checked.
- Nop-free absolute-value program on the DMEM 5/7 data -> $11=2, DMEM cells swapped; repeat with cells 7/5 -> beq taken, no swap, $11=2.
- run=0 for 10 cycles mid-program while imem_we writes an unreached address -> no state change; resumed program completes with identical results; retired count correct.
